axi4_lite_dma_copy: RTL and testbench

Single-channel memory-to-memory copy engine acting as an AXI4-Lite master. A command requests a copy of `cmd_len` words from `cmd_src` to `cmd_dst`. The engine copies one word at a time: one AR/R read, then one AW/W/B write. It drives our AXI4-Lite RAM slaves, which use word addressing, so the address advances by 1 per word.

---
 rtl/axi4_lite_dma_copy.sv | 152 +++++++++++++++
 tb/tb_axi4_lite_dma_copy.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_dma_copy.sv
// Single-channel AXI4-Lite memory-to-memory copy engine.
// Copies one word at a time (AR/R, then AW/W/B) using word addressing.
module axi4_lite_dma_copy #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cmd_start,
  input  logic [ADDR_WIDTH-1:0]   cmd_src,
  input  logic [ADDR_WIDTH-1:0]   cmd_dst,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [LEN_WIDTH-1:0]    xfer_count,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    error_q, error_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    aw_hs, w_hs;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      error_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      error_q   <= error_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // AW and W complete independently; each VALID stays down once its handshake is done.
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    error_d   = error_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          len_d   = cmd_len;
          cnt_d   = '0;
          error_d = 1'b0;
          state_d = (cmd_len == '0) ? DONE : RD_A;
        end
      end
      RD_A: begin
        if (ARREADY) state_d = RD_D;
      end
      RD_D: begin
        if (RVALID) begin
          data_d = RDATA;
          if (RRESP != 2'b00) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_A;
          end
        end
      end
      WR_A: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_B;
      end
      WR_B: begin
        if (BVALID) begin
          cnt_d = cnt_inc;
          src_d = src_q + 1'b1;
          dst_d = dst_q + 1'b1;
          if (BRESP != 2'b00) begin
            error_d = 1'b1;
            state_d = DONE;
          end else if (cnt_inc == len_q) begin
            state_d = DONE;
          end else begin
            state_d = RD_A;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ARVALID    = (state_q == RD_A);
  assign RREADY     = (state_q == RD_D);
  assign AWVALID    = (state_q == WR_A) && !aw_done_q;
  assign WVALID     = (state_q == WR_A) && !w_done_q;
  assign BREADY     = (state_q == WR_B);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign xfer_count = cnt_q;
  assign ARADDR     = src_q;
  assign AWADDR     = dst_q;
  assign WDATA      = data_q;
  assign WSTRB      = '1;

endmodule

// File: tb/tb_axi4_lite_dma_copy.sv
// Bench for axi4_lite_dma_copy: randomly stalling AXI4-Lite RAM slave plus a
// sequential-copy reference model of memory and of the expected bus traffic.
`timescale 1ns/1ps
module tb_axi4_lite_dma_copy;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int LW    = 11;
  localparam int MEMSZ = 1 << AW;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic cmd_start = 1'b0;
  logic [AW-1:0] cmd_src = '0, cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
  logic busy, done, error;
  logic [LW-1:0] xfer_count;
  logic [AW-1:0] ARADDR, AWADDR;
  logic ARVALID, RREADY, AWVALID, WVALID, BREADY;
  logic ARREADY = 1'b0, RVALID = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [DW-1:0] RDATA = '0;
  logic [DW-1:0] WDATA;
  logic [DW/8-1:0] WSTRB;
  logic [1:0] RRESP = 2'b00, BRESP = 2'b00;

  always #5 ACLK = ~ACLK;

  axi4_lite_dma_copy #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_start(cmd_start), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .busy(busy), .done(done), .error(error), .xfer_count(xfer_count),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave RAM and the reference image of it
  logic [DW-1:0] mem [MEMSZ];
  logic [DW-1:0] ref_mem [MEMSZ];

  int max_stall = 0;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  bit ar_hs_n, r_hs_n, aw_hs_n, w_hs_n, b_hs_n;
  bit rst_pend = 1'b1;
  bit r_pend, aw_got, w_got, b_pend;
  bit pv_ar, pv_aw, pv_w, any_valid;
  logic [AW-1:0] ar_addr_s, aw_addr_s, rd_addr, wr_addr, p_araddr, p_awaddr;
  logic [DW-1:0] w_data_s, wr_data, p_wdata;
  int b_idx = 0;
  int b_err_at = -1;
  logic [AW-1:0] ar_log[$];
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];

  function automatic int rnd_stall();
    return (max_stall == 0) ? 0 : int'($urandom_range(max_stall, 0));
  endfunction

  // Slave: decides READY/VALID at the falling edge; a handshake flagged here
  // takes effect at the next rising edge and is accounted for one negedge later.
  always @(negedge ACLK) begin
    if (rst_pend) begin
      ARREADY = 1'b0; RVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
      RRESP = 2'b00; BRESP = 2'b00;
      r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0;
      ar_hs_n = 1'b0; r_hs_n = 1'b0; aw_hs_n = 1'b0; w_hs_n = 1'b0; b_hs_n = 1'b0;
      pv_ar = 1'b0; pv_aw = 1'b0; pv_w = 1'b0;
      ar_wait = rnd_stall(); aw_wait = rnd_stall(); w_wait = rnd_stall();
    end else begin
      if (pv_ar) chk("ar_stable", 64'({ARVALID, ARADDR}), 64'({1'b1, p_araddr}));
      if (pv_aw) chk("aw_stable", 64'({AWVALID, AWADDR}), 64'({1'b1, p_awaddr}));
      if (pv_w)  chk("w_stable", 64'({WVALID, WDATA}), 64'({1'b1, p_wdata}));
      if (b_hs_n) begin b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_idx++; end
      if (ar_hs_n) begin
        ar_log.push_back(ar_addr_s);
        rd_addr = ar_addr_s; r_pend = 1'b1; r_wait = rnd_stall(); ar_wait = rnd_stall();
      end
      if (r_hs_n) r_pend = 1'b0;
      if (aw_hs_n) begin aw_log.push_back(aw_addr_s); wr_addr = aw_addr_s; aw_got = 1'b1; aw_wait = rnd_stall(); end
      if (w_hs_n) begin w_log.push_back(w_data_s); wr_data = w_data_s; w_got = 1'b1; w_wait = rnd_stall(); end
      if (aw_got && w_got && !b_pend) begin
        mem[wr_addr] = wr_data; b_pend = 1'b1; b_wait = rnd_stall();
      end
      if (RREADY) chk("rready_gate", 64'(r_pend), 64'(1));
      if (BREADY) chk("bready_gate", 64'(aw_got && w_got), 64'(1));

      ARREADY = 1'b0; ar_hs_n = 1'b0;
      if (ARVALID) begin
        if (ar_wait > 0) ar_wait--;
        else begin ARREADY = 1'b1; ar_hs_n = 1'b1; ar_addr_s = ARADDR; end
      end
      RVALID = 1'b0; r_hs_n = 1'b0;
      if (r_pend) begin
        if (r_wait > 0) r_wait--;
        else begin RVALID = 1'b1; RDATA = mem[rd_addr]; RRESP = 2'b00; r_hs_n = RREADY; end
      end
      AWREADY = 1'b0; aw_hs_n = 1'b0;
      if (AWVALID) begin
        if (aw_wait > 0) aw_wait--;
        else begin AWREADY = 1'b1; aw_hs_n = 1'b1; aw_addr_s = AWADDR; end
      end
      WREADY = 1'b0; w_hs_n = 1'b0;
      if (WVALID) begin
        if (w_wait > 0) w_wait--;
        else begin WREADY = 1'b1; w_hs_n = 1'b1; w_data_s = WDATA; end
      end
      BVALID = 1'b0; b_hs_n = 1'b0;
      if (b_pend) begin
        if (b_wait > 0) b_wait--;
        else begin
          BVALID = 1'b1; BRESP = (b_idx == b_err_at) ? 2'b10 : 2'b00; b_hs_n = BREADY;
        end
      end
      pv_ar = ARVALID && !ar_hs_n; p_araddr = ARADDR;
      pv_aw = AWVALID && !aw_hs_n; p_awaddr = AWADDR;
      pv_w  = WVALID && !w_hs_n;   p_wdata  = WDATA;
      if (ARVALID || AWVALID || WVALID) any_valid = 1'b1;
    end
    rst_pend = !ARESETN;
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"}, 64'({ARVALID, RREADY, AWVALID, WVALID, BREADY, busy, done, error}), 64'(0));
    chk({tag, "_count"}, 64'(xfer_count), 64'(0));
    chk({tag, "_addr"}, 64'({ARADDR, AWADDR}), 64'(0));
    chk({tag, "_wdata"}, 64'(WDATA), 64'(0));
    chk({tag, "_wstrb"}, 64'(WSTRB), 64'({(DW/8){1'b1}}));
  endtask

  // One command: reference = plain ascending copy on ref_mem, stopping after err_at.
  task automatic run_cmd(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                         input int err_at, input bit poke_busy, input int exp_lat);
    logic [AW-1:0] exp_ar[$];
    logic [AW-1:0] exp_aw[$];
    logic [DW-1:0] exp_w[$];
    logic [AW-1:0] s, d;
    int nwords, lat, diffs;
    bit exp_err;
    exp_err = (err_at >= 0 && err_at < len);
    nwords = exp_err ? err_at + 1 : len;
    for (int i = 0; i < nwords; i++) begin
      s = src + AW'(i);
      d = dst + AW'(i);
      exp_ar.push_back(s);
      exp_aw.push_back(d);
      exp_w.push_back(ref_mem[s]);
      ref_mem[d] = ref_mem[s];
    end
    b_err_at = err_at; b_idx = 0; any_valid = 1'b0;
    ar_log.delete(); aw_log.delete(); w_log.delete();

    cmd_src = src; cmd_dst = dst; cmd_len = LW'(len); cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    cmd_src = AW'($urandom); cmd_dst = AW'($urandom); cmd_len = LW'($urandom);
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_clears", 64'({error, xfer_count}), 64'(0));
    if (len > 0) chk("start_arvalid", 64'(ARVALID), 64'(1));
    lat = 1;
    while (!done && lat < 4000) begin
      if (poke_busy && $urandom_range(3, 0) == 0) begin
        cmd_start = 1'b1; cmd_src = AW'($urandom); cmd_dst = AW'($urandom); cmd_len = LW'($urandom);
      end else begin
        cmd_start = 1'b0;
      end
      step();
      lat++;
    end
    cmd_start = 1'b0;
    chk("done_seen", 64'(done), 64'(1));
    chk("done_busy", 64'(busy), 64'(1));
    chk("xfer_count", 64'(xfer_count), 64'(nwords));
    chk("error_flag", 64'(error), 64'(exp_err));
    if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
    if (len == 0) begin
      chk("zero_len_latency", 64'(lat <= 2), 64'(1));
      chk("zero_len_no_valid", 64'(any_valid), 64'(0));
    end
    step();
    chk("done_pulse", 64'({done, busy}), 64'(0));
    chk("ar_count", 64'(ar_log.size()), 64'(exp_ar.size()));
    chk("aw_count", 64'(aw_log.size()), 64'(exp_aw.size()));
    chk("w_count", 64'(w_log.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) chk("ar_addr", 64'(ar_log[i]), 64'(exp_ar[i]));
    for (int i = 0; i < exp_aw.size() && i < aw_log.size(); i++) chk("aw_addr", 64'(aw_log[i]), 64'(exp_aw[i]));
    for (int i = 0; i < exp_w.size() && i < w_log.size(); i++) chk("w_data", 64'(w_log[i]), 64'(exp_w[i]));
    diffs = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", 64'(diffs), 64'(0));
    $display("cmd src=%03h dst=%03h len=%0d err_at=%0d: %0d words, %0d cycles, error=%0b",
             src, dst, len, err_at, xfer_count, lat, error);
  endtask

  initial begin
    int t;
    for (int i = 0; i < MEMSZ; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    for (int i = 0; i < 4; i++) begin mem[16 + i] = 32'hA0 + i; ref_mem[16 + i] = mem[16 + i]; end

    ARESETN = 1'b0;
    repeat (3) step();
    chk_reset_vals("reset");
    ARESETN = 1'b1;
    step();

    // Stall-free slave: 4 cycles per word, done one cycle after the last B
    max_stall = 0;
    run_cmd(10'h010, 10'h080, 4, -1, 1'b0, 17);
    run_cmd(10'h020, 10'h030, 0, -1, 1'b0, -1);
    run_cmd(10'h3FE, 10'h3FF, 3, -1, 1'b0, 13);

    max_stall = 5;
    for (int k = 0; k < 4; k++)
      run_cmd(AW'($urandom), AW'($urandom), int'($urandom_range(12, 1)), -1, 1'b0, -1);
    run_cmd(10'h100, 10'h200, 5, 1, 1'b0, -1);
    run_cmd(10'h140, 10'h240, 2, -1, 1'b0, -1);

    // Reset while the write address/data phase is outstanding
    max_stall = 3; b_err_at = -1;
    cmd_src = 10'h050; cmd_dst = 10'h300; cmd_len = LW'(8); cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    t = 0;
    while (!AWVALID && t < 500) begin step(); t++; end
    chk("reach_wr_a", 64'(AWVALID), 64'(1));
    ARESETN = 1'b0;
    step();
    chk_reset_vals("midreset");
    ARESETN = 1'b1;
    step();
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = mem[i];
    $display("reset mid-copy after %0d cycles in flight", t);
    run_cmd(10'h060, 10'h310, 6, -1, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
